// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage ALU plus the EX/MEM pipeline register.
// Defining EX_DIV_EN builds in a 32-cycle restoring divider for DIVU/REMU
// (ops 10/11). Without it those ops produce 0 and stall_o is tied low.
module ex_mem_stage (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   input  logic        flush_i,
   input  logic [3:0]  alu_op_i,
   input  logic [31:0] alua_i,
   input  logic [31:0] alub_i,
   input  logic [31:0] ext_i,
   input  logic [31:0] rD2_i,
   input  logic        ram_we_i,
   input  logic [1:0]  rf_wsel_i,
   output logic [31:0] alu_c_o,
   output logic [31:0] ext_o,
   output logic [31:0] rD2_o,
   output logic        ram_we_o,
   output logic [1:0]  rf_wsel_o,
   output logic        valid_o,
   output logic        stall_o
);

   function automatic logic [31:0] aluCalc(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      logic [31:0] res;
      res = 32'h0;
      case (op)
         4'd0: res = a + b;
         4'd1: res = a - b;
         4'd2: res = a & b;
         4'd3: res = a | b;
         4'd4: res = a ^ b;
         4'd5: res = a << b[4:0];
         4'd6: res = a >> b[4:0];
         4'd7: res = $signed(a) >>> b[4:0];
         4'd8: res = {31'h0, $signed(a) < $signed(b)};
         4'd9: res = {31'h0, a < b};
         default: res = 32'h0;
      endcase
      return res;
   endfunction

   logic [31:0] aluResult;
   logic        divDone;
   logic [31:0] divResult;

   assign aluResult = aluCalc(alu_op_i, alua_i, alub_i);

`ifdef EX_DIV_EN
   typedef enum logic [1:0] {IDLE, DIV, DONE} divState_t;

   divState_t   state_q, state_d;
   logic [4:0]  count_q, count_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] divisor_q, divisor_d;
   logic        isRem_q, isRem_d;
   logic        isDivOp;
   logic [32:0] remShift;
   logic [33:0] trial;

   assign isDivOp   = (alu_op_i == 4'd10) || (alu_op_i == 4'd11);
   assign stall_o   = valid_i && isDivOp && (state_q != DONE) && !flush_i;
   assign divDone   = (state_q == DONE);
   assign divResult = isRem_q ? rem_q : quo_q;

   // Divider FSM: latch operands on entry, then one restoring quotient bit per DIV cycle
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      divisor_d = divisor_q;
      isRem_d   = isRem_q;
      remShift  = {rem_q, quo_q[31]};
      trial     = {1'b0, remShift} - {2'b00, divisor_q};
      case (state_q)
         IDLE: begin
            count_d = 5'd0;
            if (!flush_i && valid_i && isDivOp) begin
               isRem_d   = (alu_op_i == 4'd11);
               divisor_d = alub_i;
               if (alub_i == 32'h0) begin
                  quo_d   = 32'hFFFF_FFFF;
                  rem_d   = alua_i;
                  state_d = DONE;
               end else begin
                  quo_d   = alua_i;
                  rem_d   = 32'h0;
                  state_d = DIV;
               end
            end
         end
         DIV: begin
            if (flush_i) begin
               state_d = IDLE;
               count_d = 5'd0;
            end else begin
               quo_d   = {quo_q[30:0], ~trial[33]};
               rem_d   = trial[33] ? remShift[31:0] : trial[31:0];
               count_d = count_q + 5'd1;
               if (count_q == 5'd31) begin
                  state_d = DONE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            count_d = 5'd0;
         end
      endcase
   end

   // Divider state registers, cleared by reset so an aborted divide leaves no trace
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         count_q   <= 5'd0;
         quo_q     <= 32'h0;
         rem_q     <= 32'h0;
         divisor_q <= 32'h0;
         isRem_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         divisor_q <= divisor_d;
         isRem_q   <= isRem_d;
      end
   end
`else
   assign stall_o   = 1'b0;
   assign divDone   = 1'b0;
   assign divResult = 32'h0;
`endif

   logic [31:0] aluC_d, ext_d, rD2_d;
   logic        ramWe_d, valid_d;
   logic [1:0]  rfWsel_d;

   // EX/MEM next state: flush kills, finished divide loads, live op loads, else bubble
   always_comb begin
      aluC_d   = alu_c_o;
      ext_d    = ext_o;
      rD2_d    = rD2_o;
      ramWe_d  = ram_we_o;
      rfWsel_d = rf_wsel_o;
      valid_d  = valid_o;
      if (flush_i) begin
         valid_d = 1'b0;
         ramWe_d = 1'b0;
      end else if (divDone || (valid_i && !stall_o)) begin
         aluC_d   = divDone ? divResult : aluResult;
         ext_d    = ext_i;
         rD2_d    = rD2_i;
         ramWe_d  = ram_we_i;
         rfWsel_d = rf_wsel_i;
         valid_d  = 1'b1;
      end else begin
         valid_d = 1'b0;
         ramWe_d = 1'b0;
      end
   end

   // EX/MEM pipeline register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         alu_c_o   <= 32'h0;
         ext_o     <= 32'h0;
         rD2_o     <= 32'h0;
         ram_we_o  <= 1'b0;
         rf_wsel_o <= 2'b00;
         valid_o   <= 1'b0;
      end else begin
         alu_c_o   <= aluC_d;
         ext_o     <= ext_d;
         rD2_o     <= rD2_d;
         ram_we_o  <= ramWe_d;
         rf_wsel_o <= rfWsel_d;
         valid_o   <= valid_d;
      end
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed and random checks of ex_mem_stage against an
// arithmetic reference model. Divider checks apply when EX_DIV_EN is defined.
module tb_ex_mem_stage;

   logic        clk_i = 1'b0;
   logic        rst_i, valid_i, flush_i, ram_we_i;
   logic [3:0]  alu_op_i;
   logic [31:0] alua_i, alub_i, ext_i, rD2_i;
   logic [1:0]  rf_wsel_i;
   logic [31:0] alu_c_o, ext_o, rD2_o;
   logic        ram_we_o, valid_o, stall_o;
   logic [1:0]  rf_wsel_o;

   int errors = 0;
   int checks = 0;

   logic [31:0] expC, expExt, expRd2;
   logic        expWe, expValid;
   logic [1:0]  expWsel;

   ex_mem_stage dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i),
      .alu_op_i(alu_op_i), .alua_i(alua_i), .alub_i(alub_i),
      .ext_i(ext_i), .rD2_i(rD2_i), .ram_we_i(ram_we_i), .rf_wsel_i(rf_wsel_i),
      .alu_c_o(alu_c_o), .ext_o(ext_o), .rD2_o(rD2_o), .ram_we_o(ram_we_o),
      .rf_wsel_o(rf_wsel_o), .valid_o(valid_o), .stall_o(stall_o)
   );

   // Free-running clock
   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      int unsigned sh;
      sh = b % 32;
      case (op)
         0: return a + b;
         1: return a - b;
         2: return a & b;
         3: return a | b;
         4: return a ^ b;
         5: return a << sh;
         6: return a >> sh;
         7: return (a[31] ? ~(~a >> sh) : (a >> sh));
         8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         9: return (a < b) ? 32'd1 : 32'd0;
`ifdef EX_DIV_EN
         10: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         11: return (b == 0) ? a : a % b;
`endif
         default: return 32'h0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic f, input logic [3:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] ext, input logic [31:0] rd2,
                                input logic we, input logic [1:0] wsel);
      valid_i = v; flush_i = f; alu_op_i = op; alua_i = a; alub_i = b;
      ext_i = ext; rD2_i = rd2; ram_we_i = we; rf_wsel_i = wsel;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".alu_c"}, alu_c_o, expC);
      checkOutput({tag, ".ext"}, ext_o, expExt);
      checkOutput({tag, ".rD2"}, rD2_o, expRd2);
      checkOutput({tag, ".ram_we"}, {31'h0, ram_we_o}, {31'h0, expWe});
      checkOutput({tag, ".wsel"}, {30'h0, rf_wsel_o}, {30'h0, expWsel});
      checkOutput({tag, ".valid"}, {31'h0, valid_o}, {31'h0, expValid});
   endtask

   task automatic modelAccept(input logic [31:0] c);
      expC = c; expExt = ext_i; expRd2 = rD2_i; expWe = ram_we_i;
      expWsel = rf_wsel_i; expValid = 1'b1;
   endtask

   task automatic modelBubble();
      expValid = 1'b0; expWe = 1'b0;
   endtask

   task automatic modelReset();
      expC = 0; expExt = 0; expRd2 = 0; expWe = 0; expWsel = 0; expValid = 0;
   endtask

   // One plain instruction presented, checked for no stall and one-cycle result
   task automatic runSingle(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic we);
      applyStimulus(1, 0, op, a, b, $urandom, $urandom, we, 2'($urandom_range(0, 3)));
      #1;
      checkOutput({tag, ".stall"}, {31'h0, stall_o}, 32'h0);
      modelAccept(refAlu(op, a, b));
      tick();
      checkAll(tag);
   endtask

`ifdef EX_DIV_EN
   // Divide held while stall_o is high; checks stall length and final result
   task automatic runDivide(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int expStall,
                            input logic [31:0] expResult);
      int cnt;
      applyStimulus(1, 0, op, a, b, $urandom, $urandom, 1'b1, 2'($urandom_range(0, 3)));
      #1;
      cnt = 0;
      modelBubble();
      while (stall_o && cnt < 40) begin
         tick();
         cnt++;
      end
      checkOutput({tag, ".stall_cycles"}, 32'(cnt), 32'(expStall));
      checkAll({tag, ".bubble"});
      modelAccept(expResult);
      tick();
      checkAll(tag);
   endtask
`endif

   initial begin
      logic [3:0]  op;
      logic [31:0] a, b;
      logic [3:0]  dirOp  [6];
      logic [31:0] dirA   [6];
      logic [31:0] dirB   [6];
      logic [31:0] dirExp [6];
      int          pulses;

      dirOp  = '{4'd7, 4'd8, 4'd9, 4'd1, 4'd5, 4'd6};
      dirA   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd1, 32'h8000_0000};
      dirB   = '{32'd4, 32'd1, 32'd1, 32'd7, 32'h3F, 32'd33};
      dirExp = '{32'hF800_0000, 32'h1, 32'h0, 32'hFFFF_FFFE, 32'h8000_0000, 32'h4000_0000};

      rst_i = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #12;
      modelReset();
      checkAll("reset");
      checkOutput("reset.stall", {31'h0, stall_o}, 32'h0);
      rst_i = 1'b0;
      tick();

      runSingle("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, 1'b0);
      checkOutput("add_wrap.zero", alu_c_o, 32'h0);

      for (int i = 0; i < 6; i++) begin
         runSingle($sformatf("dir%0d", i), dirOp[i], dirA[i], dirB[i], 1'b0);
         checkOutput($sformatf("dir%0d.const", i), alu_c_o, dirExp[i]);
      end
      runSingle("op14", 4'd14, 32'h1234, 32'h5678, 1'b1);

      applyStimulus(0, 0, 4'd0, 32'd9, 32'd9, 32'hAAAA, 32'hBBBB, 1'b1, 2'd3);
      modelBubble();
      tick();
      checkAll("invalid_hold");

      for (int i = 0; i < 60; i++) begin
`ifdef EX_DIV_EN
         op = 4'($urandom_range(0, 13));
         if (op >= 4'd10) op = op + 4'd2;
`else
         op = 4'($urandom_range(0, 15));
`endif
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, op, a, b,
                       $urandom, $urandom, 1'($urandom), 2'($urandom));
         #1;
         checkOutput("rand.stall", {31'h0, stall_o}, 32'h0);
         if (flush_i || !valid_i) modelBubble();
         else modelAccept(refAlu(op, a, b));
         tick();
         checkAll($sformatf("rand%0d", i));
      end

`ifdef EX_DIV_EN
      runDivide("divu_100_7", 4'd10, 32'd100, 32'd7, 33, 32'd14);
      runSingle("after_div_add", 4'd0, 32'd3, 32'd4, 1'b0);
      runDivide("remu_100_7", 4'd11, 32'd100, 32'd7, 33, 32'd2);
      runDivide("divu_5_0", 4'd10, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
      runDivide("remu_5_0", 4'd11, 32'd5, 32'd0, 1, 32'd5);
      for (int i = 0; i < 6; i++) begin
         a = $urandom;
         b = (i == 5) ? 32'h0 : ($urandom >> $urandom_range(0, 28));
         op = (i % 2 == 0) ? 4'd10 : 4'd11;
         runDivide($sformatf("rdiv%0d", i), op, a, b, (b == 0) ? 1 : 33, refAlu(op, a, b));
      end

      applyStimulus(1, 0, 4'd10, 32'd100, 32'd7, 32'h1, 32'h2, 1'b1, 2'd1);
      modelBubble();
      repeat (11) tick();
      flush_i = 1'b1;
      #1;
      checkOutput("flush.stall", {31'h0, stall_o}, 32'h0);
      tick();
      checkAll("flush");
      runSingle("flush_add", 4'd0, 32'd10, 32'd20, 1'b0);
      runDivide("post_flush_div", 4'd10, 32'd9, 32'd3, 33, 32'd3);

      applyStimulus(1, 0, 4'd10, 32'd1000, 32'd10, 32'h5, 32'h6, 1'b1, 2'd2);
      repeat (21) tick();
      #1;
      rst_i = 1'b1;
      #1;
      modelReset();
      checkAll("reset_mid_div");
      valid_i = 1'b0;
      #2;
      rst_i = 1'b0;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (valid_o !== 1'b0) pulses++;
      end
      checkOutput("reset_no_pulse", 32'(pulses), 32'h0);
      runSingle("store_after_reset", 4'd0, 32'h100, 32'h4, 1'b1);
      checkOutput("store_after_reset.we", {31'h0, ram_we_o}, 32'h1);
`else
      runSingle("divu_disabled", 4'd10, 32'd100, 32'd7, 1'b0);
      checkOutput("divu_disabled.zero", alu_c_o, 32'h0);
      runSingle("remu_disabled", 4'd11, 32'd100, 32'd7, 1'b1);
      checkOutput("remu_disabled.zero", alu_c_o, 32'h0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: clock; all state updates on rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port valid_i, input, 1 bit: ID/EX register holds a live instruction.
REQ-004 SHALL have port flush_i, input, 1 bit: synchronous kill of the instruction in this stage.
REQ-005 SHALL have ports alu_op_i (4 bits), alua_i (32 bits) and alub_i (32 bits), all inputs: ALU opcode and operands from ID/EX.
REQ-006 SHALL have ports ext_i (32 bits), rD2_i (32 bits), ram_we_i (1 bit) and rf_wsel_i (2 bits), all inputs: carried to MEM unchanged.
REQ-007 SHALL have port alu_c_o, output, 32 bits: registered ALU/divider result.
REQ-008 SHALL have ports ext_o (32 bits), rD2_o (32 bits), ram_we_o (1 bit) and rf_wsel_o (2 bits), all outputs: registered copies of the matching inputs.
REQ-009 SHALL have port valid_o, output, 1 bit: EX/MEM register holds a live instruction.
REQ-010 SHALL have port stall_o, output, 1 bit, combinational: upstream SHALL hold ID/EX contents while high.

Function
REQ-011 alu_op encoding SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU, 10 DIVU, 11 REMU, 12-15 result 0.
REQ-012 Shift amount SHALL be alub_i[4:0]; ADD/SUB SHALL wrap modulo 2^32; SLT/SLTU SHALL produce 32'h1 or 32'h0.
REQ-013 Non-divide op with valid_i=1 and stall_o=0 SHALL load all EX/MEM outputs on the next edge with valid_o=1 (1-cycle latency).
REQ-014 valid_i=0 SHALL load valid_o=0 and ram_we_o=0; the other outputs SHALL hold their values.
REQ-015 Divide FSM SHALL have states IDLE, DIV and DONE.
REQ-016 FSM SHALL go IDLE->DIV on valid_i and op 10/11 with nonzero alub_i.
REQ-017 FSM SHALL stay in DIV for exactly 32 cycles (5-bit counter, one restoring quotient bit per cycle), then go DIV->DONE.
REQ-018 FSM SHALL go DONE->IDLE unconditionally.
REQ-019 stall_o SHALL be 1 when valid_i=1, op is 10/11, state!=DONE and flush_i=0; otherwise 0.
REQ-020 In DONE the result SHALL load into alu_c_o with valid_o=1; total latency SHALL be 34 edges from first presentation, with stall_o high for 33 cycles.
REQ-021 Divide by zero SHALL go IDLE->DONE, giving quotient 32'hFFFFFFFF and remainder alua_i, with stall_o high for 1 cycle.
REQ-022 Divider SHALL compute from internally latched operands; input changes during DIV SHALL be ignored.
REQ-023 flush_i=1 SHALL have highest priority: next edge valid_o=0, ram_we_o=0, FSM->IDLE, counter cleared; stall_o SHALL be 0 in that cycle.
REQ-024 A non-divide instruction following a divide SHALL be accepted in the cycle after DONE with no extra bubble.

Reset
REQ-025 rst_i high SHALL immediately force alu_c_o, ext_o, rD2_o and rf_wsel_o to 0, ram_we_o=0, valid_o=0, FSM IDLE and counter 0.
REQ-026 Reset asserted mid-divide SHALL abort the divide with no result emitted; after release the FSM SHALL start from IDLE.

Configuration
REQ-027 Macro EX_DIV_EN defined SHALL compile in the divider FSM and ops 10/11 as specified.
REQ-028 EX_DIV_EN undefined SHALL remove the divider: ops 10/11 SHALL produce 0 with 1-cycle latency and stall_o SHALL be tied to 0.

Verification
REQ-029 ADD, 32'hFFFFFFFF + 1, valid_i=1 -> next edge alu_c_o=0, valid_o=1, stall_o stays 0.
REQ-030 SRA, 32'h80000000 >> 4 -> alu_c_o=32'hF8000000; SLT with -1 < 1 -> 32'h1; SLTU with same operands -> 32'h0.
REQ-031 DIVU 100/7 held per stall_o -> stall_o high 33 cycles, alu_c_o=14 at edge 34; REMU same operands -> 2.
REQ-032 DIVU 5/0 -> stall_o high 1 cycle, alu_c_o=32'hFFFFFFFF; REMU 5/0 -> 5.
REQ-033 flush_i at DIV cycle 10 -> valid_o=0, ram_we_o=0, FSM IDLE, stall_o=0; next ADD completes in 1 cycle.
REQ-034 rst_i pulse at DIV cycle 20 -> all outputs 0 immediately; no valid_o pulse follows; ram_we_i=1 store after release -> ram_we_o=1 next edge.
